// File: rtl/pim_result_collector.sv
// Result collector: drains CHUNK x CHUNK tiles from a grid of PIM units and
// writes each element back to its row-major slot in the C-matrix region.
module pim_result_collector #(
   parameter int NUM_PIM_UNITS = 4,
   parameter int MATRIX_SIZE   = 16,
   parameter int WIDTH         = 32,
   parameter int LEN           = 10
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [LEN-1:0]                 base_addr,
   output logic                           busy,
   output logic                           done,
   input  logic [NUM_PIM_UNITS-1:0]       res_valid,
   input  logic [NUM_PIM_UNITS*WIDTH-1:0] res_data,
   output logic [NUM_PIM_UNITS-1:0]       res_ready,
   output logic                           mem_valid,
   output logic [LEN-1:0]                 mem_addr,
   output logic [WIDTH-1:0]               mem_wdata,
   input  logic                           mem_ready
);

   localparam int GRID       = 1 << ($clog2(NUM_PIM_UNITS) / 2);
   localparam int CHUNK      = MATRIX_SIZE / GRID;
   localparam int TILE_ELEMS = CHUNK * CHUNK;
   localparam int UW         = (NUM_PIM_UNITS > 1) ? $clog2(NUM_PIM_UNITS) : 1;
   localparam int EW         = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;
   localparam int OW         = LEN + 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_r;
   logic [LEN-1:0]   base_r;
   logic [UW-1:0]    unit_idx_r;
   logic [EW-1:0]    elem_idx_r;
   logic             busy_r;
   logic             done_r;
   logic             mem_valid_r;
   logic [LEN-1:0]   mem_addr_r;
   logic [WIDTH-1:0] mem_wdata_r;

   logic             can_load_s;
   logic             accept_s;
   logic             last_elem_s;
   logic             last_unit_s;
   logic [WIDTH-1:0] cur_data_s;
   logic [LEN-1:0]   cur_addr_s;

   // Offset is formed at LEN+2 bits, then the sum wraps modulo 2^LEN.
   function automatic logic [LEN-1:0] calc_addr(input logic [LEN-1:0] base,
                                                input logic [UW-1:0]  unit,
                                                input logic [EW-1:0]  elem);
      logic [OW-1:0] r, c, tr, tc, off, sum;
      r   = OW'(elem) / OW'(CHUNK);
      c   = OW'(elem) % OW'(CHUNK);
      tr  = OW'(unit) / OW'(GRID);
      tc  = OW'(unit) % OW'(GRID);
      off = (tr * OW'(CHUNK) + r) * OW'(MATRIX_SIZE) + tc * OW'(CHUNK) + c;
      sum = OW'(base) + off;
      return sum[LEN-1:0];
   endfunction

   assign can_load_s  = !mem_valid_r || mem_ready;
   assign accept_s    = (state_r == S_DRAIN) && res_valid[unit_idx_r] && can_load_s;
   assign last_elem_s = (elem_idx_r == EW'(TILE_ELEMS - 1));
   assign last_unit_s = (unit_idx_r == UW'(NUM_PIM_UNITS - 1));
   assign cur_data_s  = res_data[int'(unit_idx_r) * WIDTH +: WIDTH];
   assign cur_addr_s  = calc_addr(base_r, unit_idx_r, elem_idx_r);

   // Ready goes only to the unit being drained, and only when the output stage can take data.
   always_comb begin
      res_ready = {NUM_PIM_UNITS{1'b0}};
      if (state_r == S_DRAIN) begin
         res_ready[unit_idx_r] = can_load_s;
      end else begin
         res_ready = {NUM_PIM_UNITS{1'b0}};
      end
   end

   // Sequencing FSM with element/unit counters and busy/done flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         base_r     <= {LEN{1'b0}};
         unit_idx_r <= {UW{1'b0}};
         elem_idx_r <= {EW{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  base_r     <= base_addr;
                  unit_idx_r <= {UW{1'b0}};
                  elem_idx_r <= {EW{1'b0}};
                  busy_r     <= 1'b1;
                  state_r    <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (accept_s) begin
                  if (last_elem_s) begin
                     elem_idx_r <= {EW{1'b0}};
                     unit_idx_r <= unit_idx_r + UW'(1);
                     if (last_unit_s) begin
                        state_r <= S_FLUSH;
                     end
                  end else begin
                     elem_idx_r <= elem_idx_r + EW'(1);
                  end
               end
            end
            S_FLUSH: begin
               if (mem_ready) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= S_DONE;
               end
            end
            S_DONE: begin
               done_r  <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   // Single output stage; holds steady while the memory stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_valid_r <= 1'b0;
         mem_addr_r  <= {LEN{1'b0}};
         mem_wdata_r <= {WIDTH{1'b0}};
      end else if (accept_s) begin
         mem_valid_r <= 1'b1;
         mem_addr_r  <= cur_addr_s;
         mem_wdata_r <= cur_data_s;
      end else if (mem_ready) begin
         mem_valid_r <= 1'b0;
      end else begin
         mem_valid_r <= mem_valid_r;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign mem_valid = mem_valid_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_pim_result_collector.sv
// Randomized scoreboard bench for pim_result_collector: expected writes are
// queued at start from a matrix-level model and checked by a separate monitor.
module tb_pim_result_collector;

   localparam int NU = 4;
   localparam int N  = 16;
   localparam int W  = 32;
   localparam int L  = 10;
   localparam int G  = 2;
   localparam int C  = 8;
   localparam int TE = 64;
   localparam int TOTAL = N * N;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [L-1:0]    base_addr;
   logic            busy;
   logic            done;
   logic [NU-1:0]   res_valid;
   logic [NU*W-1:0] res_data;
   logic [NU-1:0]   res_ready;
   logic            mem_valid;
   logic [L-1:0]    mem_addr;
   logic [W-1:0]    mem_wdata;
   logic            mem_ready;

   always #5 clk = ~clk;

   pim_result_collector #(.NUM_PIM_UNITS(NU), .MATRIX_SIZE(N), .WIDTH(W), .LEN(L)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .busy(busy), .done(done),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready)
   );

   typedef struct packed {
      logic [L-1:0] a;
      logic [W-1:0] d;
   } wr_t;

   int          checks = 0;
   int          failures = 0;
   wr_t         exp_q[$];
   logic [W-1:0] tile [NU][TE];
   int          ptr [NU];
   bit          all_valid = 1'b1;
   bit          rand_ready = 1'b0;
   bit          full_speed = 1'b0;
   int          stall_left = 0;
   int          run_base = -1;
   int          cyc = 0;
   int          hs_cnt = 0;
   int          acc_cnt = 0;
   int          done_cnt = 0;
   int          busy_cnt = 0;
   int          start_cyc = 0;
   int          last_hs_cyc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Matrix-level placement of element e of unit u.
   function automatic int model_addr(input int base, input int u, input int e);
      int row, col;
      row = (u / G) * C + e / C;
      col = (u % G) * C + e % C;
      return (base + row * N + col) % (1 << L);
   endfunction

   // Unit stream sources and memory ready driver.
   initial begin : unit_drv
      logic [NU-1:0] fire;
      for (int u = 0; u < NU; u++) ptr[u] = TE;
      res_valid = '0;
      res_data  = '0;
      mem_ready = 1'b0;
      forever begin
         @(negedge clk);
         fire = res_valid & res_ready & {NU{~rst}};
         @(posedge clk);
         #2;
         for (int u = 0; u < NU; u++) begin
            if (fire[u]) ptr[u]++;
            res_valid[u] = (ptr[u] < TE) && (all_valid || ($urandom_range(3) != 0));
            res_data[u*W +: W] = (ptr[u] < TE) ? tile[u][ptr[u]] : '0;
         end
         if (stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
         end else begin
            mem_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on every memory handshake.
   initial begin : monitor
      bit           stall_prev = 1'b0;
      logic [L-1:0] prev_a;
      logic [W-1:0] prev_d;
      logic [NU-1:0] allowed;
      wr_t          e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            exp_q.delete();
            hs_cnt = 0;
            acc_cnt = 0;
            stall_prev = 1'b0;
         end else begin
            if (start && !busy && !done) begin
               start_cyc = cyc;
               busy_cnt = 0;
               hs_cnt = 0;
               acc_cnt = 0;
            end
            if (busy) busy_cnt++;
            allowed = (busy && acc_cnt < TOTAL) ? NU'(1) << (acc_cnt / TE) : '0;
            if ((res_ready & ~allowed) != '0) chk("res_ready_unit", res_ready, allowed);
            if (stall_prev) begin
               chk("stall_valid", mem_valid, 1'b1);
               chk("stall_addr", mem_addr, prev_a);
               chk("stall_data", mem_wdata, prev_d);
            end
            if (mem_valid && !mem_ready) chk("stall_ready_zero", res_ready, '0);
            stall_prev = mem_valid && !mem_ready;
            prev_a = mem_addr;
            prev_d = mem_wdata;
            acc_cnt += $countones(res_valid & res_ready);
            if (mem_valid && mem_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_write", mem_addr, '1);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", mem_addr, e.a);
                  chk("wr_data", mem_wdata, e.d);
                  if (run_base == 0 && hs_cnt == 0)   chk("spot_u0e0", mem_addr, 0);
                  if (run_base == 0 && hs_cnt == 8)   chk("spot_u0e8", mem_addr, 16);
                  if (run_base == 0 && hs_cnt == 64)  chk("spot_u1e0", mem_addr, 8);
                  if (run_base == 0 && hs_cnt == 128) chk("spot_u2e0", mem_addr, 128);
                  if (run_base == 0 && hs_cnt == 255) chk("spot_u3e63", mem_addr, 255);
                  if (run_base == 1000 && hs_cnt == 0)   chk("spot_b1000_first", mem_addr, 1000);
                  if (run_base == 1000 && hs_cnt == 255) chk("spot_b1000_last", mem_addr, 231);
               end
               hs_cnt++;
               last_hs_cyc = cyc;
            end
            if (done) begin
               done_cnt++;
               chk("done_after_last_hs", cyc - last_hs_cyc, 1);
               chk("done_busy_low", busy, 1'b0);
               chk("done_hs_total", hs_cnt, TOTAL);
               chk("done_queue_empty", exp_q.size(), 0);
               chk("busy_span", busy_cnt, cyc - start_cyc - 1);
               if (full_speed) chk("full_speed_latency", cyc - start_cyc, TOTAL + 2);
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_mem_valid"}, mem_valid, 1'b0);
      chk({tag, "_mem_addr"}, mem_addr, '0);
      chk({tag, "_mem_wdata"}, mem_wdata, '0);
      chk({tag, "_res_ready"}, res_ready, '0);
   endtask

   // One collection; optional mid-run stall, repeated start, or reset abort.
   task automatic run(input int base, input bit av, input bit rr, input bit fs,
                      input int stall_at, input int restart_at, input bit abort);
      int  d0;
      bit  stalled = 1'b0;
      bit  restarted = 1'b0;
      bit  finished = 1'b0;
      wr_t e;
      all_valid  = av;
      rand_ready = rr;
      full_speed = fs;
      run_base   = base;
      for (int u = 0; u < NU; u++) begin
         for (int k = 0; k < TE; k++) tile[u][k] = $urandom;
         ptr[u] = 0;
      end
      for (int u = 0; u < NU; u++) begin
         for (int k = 0; k < TE; k++) begin
            e.a = L'(model_addr(base, u, k));
            e.d = tile[u][k];
            exp_q.push_back(e);
         end
      end
      d0 = done_cnt;
      base_addr = L'(base);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = L'($urandom);
      for (int t = 0; t < 5000 && !finished; t++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (stall_at >= 0 && !stalled && hs_cnt >= stall_at) begin
            stall_left = 3;
            stalled = 1'b1;
         end
         if (restart_at >= 0 && !restarted && hs_cnt >= restart_at) begin
            start = 1'b1;
            base_addr = L'(500);
            restarted = 1'b1;
         end
         if (abort && hs_cnt >= 40) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            for (int u = 0; u < NU; u++) ptr[u] = TE;
            check_reset_outputs("abort_reset");
            repeat (5) @(posedge clk);
            #1;
            chk("abort_no_done", done_cnt, d0);
            return;
         end
         if (done_cnt != d0) finished = 1'b1;
      end
      if (!finished) chk("timeout_waiting_done", 0, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("single_done", done_cnt, d0 + 1);
   endtask

   initial begin : stim
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_outputs("init_reset");
      @(posedge clk); #1;
      run(0, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0);
      run(0, 1'b1, 1'b0, 1'b0, 70, -1, 1'b0);
      run(1000, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0);
      run(0, 1'b0, 1'b1, 1'b0, -1, 100, 1'b0);
      run(0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1);
      run(0, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         run(int'($urandom_range(1023)), 1'b0, 1'b1, 1'b0, 150, -1, 1'b0);
      end
      chk("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pim_result_collector.md
Name: pim_result_collector

Overview:
- Drains the result tiles produced by the PIM units and writes them back to the C-matrix region of result memory. This is the return path, opposite the distribution of operand chunks to the units.
- Units form a sqrt(NUM_PIM_UNITS) x sqrt(NUM_PIM_UNITS) grid. Each unit owns one CHUNK x CHUNK output tile and streams it row-major over a valid/ready interface.
- The collector visits units in order, translates each element to its row-major matrix address and issues one memory write per element, at up to one per cycle.

Parameters:
- NUM_PIM_UNITS, 4, number of PIM units; must be an even power of 2 (perfect square).
- MATRIX_SIZE, 16, result matrix dimension N (N x N).
- WIDTH, 32, data width.
- LEN, 10, memory address width.
- Derived, not overridable: GRID = sqrt(NUM_PIM_UNITS) = 2; CHUNK = MATRIX_SIZE/GRID = 8; TILE_ELEMS = CHUNK*CHUNK = 64.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse that begins a collection; sampled only in IDLE.
- base_addr  input  LEN  C-matrix base address; captured on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the final memory write handshake.
- res_valid  input  NUM_PIM_UNITS  per-unit result valid.
- res_data  input  NUM_PIM_UNITS*WIDTH  per-unit result data; unit u occupies bits [u*WIDTH +: WIDTH].
- res_ready  output  NUM_PIM_UNITS  per-unit ready; at most one bit high (one-hot or zero).
- mem_valid  output  1  write request valid.
- mem_addr  output  LEN  write address.
- mem_wdata  output  WIDTH  write data.
- mem_ready  input  1  memory accepts the write when mem_valid && mem_ready.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, mem_valid=0, mem_addr=0, mem_wdata=0, res_ready=0; unit_idx=0, elem_idx=0.
- States:
  - IDLE: on start, capture base_addr, clear counters, go to DRAIN.
  - DRAIN: runs until the last element of unit NUM_PIM_UNITS-1 is accepted, then goes to FLUSH.
  - FLUSH: waits for the final mem handshake, then goes to DONE.
  - DONE: pulses done for one cycle, then returns to IDLE.
- start is ignored in all states other than IDLE.
- Output register: a single stage holding mem_valid, mem_addr and mem_wdata.
  - can_load = !mem_valid || mem_ready.
  - In DRAIN, res_ready[unit_idx] = can_load and all other bits are 0. res_ready is combinational from state, unit_idx, mem_valid and mem_ready.
- Accept: an element is accepted when res_valid[unit_idx] && res_ready[unit_idx]. On accept:
  - mem_valid <= 1; mem_wdata <= that unit's data slice; mem_addr <= computed address.
  - elem_idx increments. When it reaches TILE_ELEMS-1 it wraps to 0 and unit_idx increments.
- Completion without accept: if mem_ready is high and no accept occurs that cycle, mem_valid <= 0.
- Latency and throughput:
  - An element accepted at cycle N appears on the mem port at N+1.
  - With continuous valid and ready, throughput is 1 element per cycle.
- Address computation:
  - r = elem_idx / CHUNK; c = elem_idx % CHUNK.
  - tr = unit_idx / GRID; tc = unit_idx % GRID.
  - addr = base_addr + (tr*CHUNK + r)*MATRIX_SIZE + tc*CHUNK + c, truncated to LEN bits (modulo 2^LEN wrap).
  - The offset is computed at LEN+2 bits before truncation.
- Backpressure: while mem_valid && !mem_ready, mem_addr and mem_wdata hold stable and no unit sees ready.
- Data from non-current units is never accepted; their res_valid may stay high indefinitely.
- done asserts in the cycle after the last handshake; busy deasserts in that same cycle.
- Total handshakes per collection = MATRIX_SIZE^2 exactly.
- Reset mid-operation returns everything to reset values. Partially written data is not rewritten, and no done is produced.

Test Plan:
- base_addr=0, all units valid every cycle, mem_ready=1 -> 256 writes on consecutive cycles:
  - unit0 elem0 -> addr 0; unit0 elem8 -> addr 16.
  - unit1 elem0 -> addr 8; unit2 elem0 -> addr 128; unit3 elem63 -> addr 255.
  - done pulses 1 cycle after the last write; busy spans start+1 to that cycle.
- mem_ready held low for 3 cycles mid-unit1 -> mem_addr/mem_wdata stable; res_ready=0000 during the stall; no element lost or duplicated; data ordering matches the per-unit streams.
- base_addr=1000 -> unit0 elem0 -> addr 1000; unit3 elem63 -> addr 231 (1255 mod 1024).
- Unit2 res_valid high from cycle 0 while unit0 is draining -> no res_ready[2] until unit_idx=2; the first unit2 write carries unit2's first element at addr 128.
- start pulsed again during DRAIN -> ignored; base unchanged; exactly 256 writes and a single done.
- rst asserted after 40 writes -> next cycle all outputs are at reset values; a subsequent start with base 0 restarts from unit0 elem0 at addr 0.
